// File: rtl/writeback_retire_if.sv
// Handshake bus for the writeback/retire queue: producer side (in_*) and
// consumer side (out_*). The queue itself attaches through the slave modport.
interface writeback_retire_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_branch;
  logic [3:0]      in_cond;
  logic            in_zero;
  logic            in_carry;
  logic            in_neg;
  logic            in_ovf;
  logic            in_wback;
  logic [REGW-1:0] in_wreg;
  logic [XLEN-1:0] in_wdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic            out_taken;
  logic            out_wback;
  logic [REGW-1:0] out_wreg;
  logic [XLEN-1:0] out_wdata;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_pc, in_branch, in_cond,
           in_zero, in_carry, in_neg, in_ovf,
           in_wback, in_wreg, in_wdata, out_ready,
    output in_ready, out_valid, out_pc, out_taken,
           out_wback, out_wreg, out_wdata, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_branch, in_cond,
           in_zero, in_carry, in_neg, in_ovf,
           in_wback, in_wreg, in_wdata, out_ready,
    input  in_ready, out_valid, out_pc, out_taken,
           out_wback, out_wreg, out_wdata, out_illegal
  );
endinterface

// File: rtl/writeback_retire.sv
// Writeback/retire queue: resolves the branch condition at enqueue time and
// holds resolved entries in a DEPTH-entry FIFO until the consumer retires them.
module writeback_retire #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_retire_if.slave    bus,
  output logic [31:0]          retired_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic            wback;
    logic [REGW-1:0] wreg;
    logic [XLEN-1:0] wdata;
    logic            illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          res;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            enq;
  logic            deq;
  logic            taken;
  logic            illegal;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign bus.in_ready  = !full && !rst;
  assign bus.out_valid = !empty;

  // in_ready already carries !rst; deq is gated so reset wins over a retire
  assign enq = bus.in_valid && bus.in_ready;
  assign deq = bus.out_valid && bus.out_ready && !rst;

  // Condition resolution and x0-write suppression for the incoming entry
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (bus.in_cond)
      4'd0:    taken = 1'b0;
      4'd1:    taken = 1'b1;
      4'd2:    taken = bus.in_zero;
      4'd3:    taken = !bus.in_zero;
      4'd4:    taken = bus.in_carry;
      4'd5:    taken = !bus.in_carry;
      4'd6:    taken = bus.in_neg;
      4'd7:    taken = !bus.in_neg;
      4'd8:    taken = bus.in_ovf;
      4'd9:    taken = !bus.in_ovf;
      default: illegal = 1'b1;
    endcase
    res         = '0;
    res.pc      = illegal ? '0 : (taken ? bus.in_branch : bus.in_pc);
    res.taken   = taken;
    res.wback   = bus.in_wback && !illegal && (bus.in_wreg != '0);
    res.wreg    = bus.in_wreg;
    res.wdata   = bus.in_wdata;
    res.illegal = illegal;
  end

  // Entry storage; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= res;
    end
  end

  // Pointers, occupancy and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      retired_count <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr        <= rd_ptr + AW'(1);
        retired_count <= retired_count + 32'd1;
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head outputs forced to zero whenever the queue is empty
  always_comb begin
    head            = mem[rd_ptr];
    bus.out_pc      = '0;
    bus.out_taken   = 1'b0;
    bus.out_wback   = 1'b0;
    bus.out_wreg    = '0;
    bus.out_wdata   = '0;
    bus.out_illegal = 1'b0;
    if (!empty) begin
      bus.out_pc      = head.pc;
      bus.out_taken   = head.taken;
      bus.out_wback   = head.wback;
      bus.out_wreg    = head.wreg;
      bus.out_wdata   = head.wdata;
      bus.out_illegal = head.illegal;
    end
  end
endmodule

// File: doc/writeback_retire.md
WRITEBACK_RETIRE -- requirements
Module: writeback_retire

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning the data and PC width.
REQ-002 The module SHALL have parameter REGW, default 5, meaning the register-index width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning the retire-queue entry count; legal values are powers of two, at least 2.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high (ports clk and rst).
REQ-005 The module SHALL have ports: clk  in  1  rising-edge clock.
REQ-006 The module SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-007 The module SHALL have ports: in_valid  in  1  upstream entry offered.
REQ-008 The module SHALL have ports: in_ready  out  1  queue can accept.
REQ-009 The module SHALL have ports: in_pc, in_branch  in  XLEN  fall-through PC and branch target.
REQ-010 The module SHALL have ports: in_cond  in  4  condition code.
REQ-011 The module SHALL have ports: in_zero, in_carry, in_neg, in_ovf  in  1 each  ALU flags.
REQ-012 The module SHALL have ports: in_wback  in  1 (write enable), in_wreg  in  REGW (destination), in_wdata  in  XLEN (write data).
REQ-013 The module SHALL have ports: out_valid  out  1  head entry valid.
REQ-014 The module SHALL have ports: out_ready  in  1  consumer accepts head.
REQ-015 The module SHALL have ports: out_pc  out  XLEN  resolved next PC; out_taken  out  1  branch taken.
REQ-016 The module SHALL have ports: out_wback  out  1, out_wreg  out  REGW, out_wdata  out  XLEN  register write.
REQ-017 The module SHALL have ports: out_illegal  out  1  unknown condition code; retired_count  out  32  dequeue counter.

Function
REQ-018 Resolution SHALL be combinational at enqueue; the resolved entry {pc, taken, wback, wreg, wdata, illegal} SHALL be stored.
REQ-019 in_cond encoding SHALL be: 0 Never, 1 Always, 2 Zero, 3 NotZero, 4 Carry, 5 NotCarry, 6 Neg, 7 NotNeg, 8 Ovf, 9 NotOvf.
REQ-020 For codes 2-9, the module SHALL set taken=1 when the named flag equals 1 (Zero/Carry/Neg/Ovf) or 0 (Not* codes); Never gives taken=0; Always gives taken=1.
REQ-021 The stored pc SHALL be in_branch when taken, else in_pc.
REQ-022 For codes 10-15, the module SHALL store pc=0, taken=0, wback=0, illegal=1.
REQ-023 When in_wreg==0, the stored wback SHALL be 0 (x0 write suppressed); wreg and wdata SHALL be stored unchanged.
REQ-024 in_ready SHALL equal (!full && !rst); the module SHALL enqueue on the rising edge when in_valid && in_ready.
REQ-025 out_valid SHALL equal !empty; the module SHALL dequeue on the rising edge when out_valid && out_ready.
REQ-026 Enqueue-to-out_valid latency SHALL be 1 cycle; there SHALL be no combinational in-to-out bypass.
REQ-027 Simultaneous enqueue and dequeue SHALL leave the occupancy unchanged; when full, in_ready=0 even if out_ready=1.
REQ-028 Occupancy SHALL use DEPTH+1 states, with pointer wrap modulo DEPTH; full means occupancy==DEPTH and empty means occupancy==0.
REQ-029 While out_valid=0, all out_* data outputs and out_taken/out_wback/out_illegal SHALL be 0.
REQ-030 retired_count SHALL increment by 1 per dequeue and wrap from 0xFFFFFFFF to 0.
REQ-031 The module SHALL NOT change head outputs while out_valid && !out_ready (stable under backpressure).

Reset
REQ-032 While rst is high at a clock edge, the module SHALL clear occupancy, pointers and retired_count to 0.
REQ-033 During and after reset until the next enqueue, outputs SHALL be: out_valid=0, all out_* =0, in_ready=0 while rst high and 1 the first cycle after.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; the module SHALL NOT dequeue or enqueue in that cycle.
REQ-035 Queue storage SHALL NOT require reset.

Verification
REQ-036 Scenario: enqueue cond=2, zero=1, pc=0x100, branch=0x200, wreg=5, wdata=0xAB, wback=1 -> next cycle out_valid=1, out_pc=0x200, out_taken=1, out_wback=1, out_wreg=5.
REQ-037 Scenario: enqueue cond=5, carry=1, pc=0x104 -> out_pc=0x104, out_taken=0; then cond=12 -> out_pc=0, out_illegal=1, out_wback=0.
REQ-038 Scenario: enqueue wreg=0, wback=1, wdata=0xFF -> out_wback=0, out_wdata=0xFF.
REQ-039 Scenario: out_ready=0, enqueue 4 entries with DEPTH=4 -> in_ready=0 after the 4th; hold 3 cycles with head stable; then out_ready=1 -> 4 entries retire in FIFO order and retired_count=4.
REQ-040 Scenario: continuous in_valid=1 and out_ready=1 for 10 cycles -> occupancy stays at 1, 9 retirements by cycle 10, in_ready=1 throughout.
REQ-041 Scenario: 3 entries queued, rst=1 for 1 cycle -> out_valid=0 and retired_count=0 next cycle; no queued entry is ever presented.
